// File: rtl/ex_muldiv_pkg.sv
// Shared constants and helpers for the EX-stage RV64M multiply/divide unit.
// Holds the funct3 codes, the FSM state encodings and the iteration counter sizing.
package ex_muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

    localparam logic [1:0] MULDIV_IDLE = 2'd0;
    localparam logic [1:0] MULDIV_CALC = 2'd1;
    localparam logic [1:0] MULDIV_DONE = 2'd2;

    localparam int MULDIV_CNT_W = 6;
    localparam logic [MULDIV_CNT_W-1:0] MULDIV_CNT_FULL = 6'd63;
    localparam logic [MULDIV_CNT_W-1:0] MULDIV_CNT_WORD = 6'd31;

    function automatic logic [63:0] sext_word(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    // Applies the result sign to the unsigned magnitude product, then picks the half.
    function automatic logic [63:0] mul_select(input logic [2:0] op, input logic neg,
                                               input logic [127:0] prod);
        logic [127:0] p;
        p = neg ? -prod : prod;
        return (op == MULDIV_OP_MUL) ? p[63:0] : p[127:64];
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and emit the quotient bit.
module ex_div_step
    import ex_muldiv_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // rem_in < divisor always holds, so the top bit of diff is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, quo_in[W-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[W]) begin
            rem_out = diff[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b1};
        end else begin
            rem_out = shifted[W-1:0];
            quo_out = {quo_in[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV64M multiply/divide unit for the EX stage (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle 64x64 multiplier.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]              state_q, state_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]              op_q, op_d;
    logic                    word_q, word_d;
    logic                    neg_q, neg_d;
    logic [63:0]             opnd_q, opnd_d;
    logic [127:0]            acc_q, acc_d;
    logic [63:0]             result_q, result_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic        signed_a, signed_b, sign_a, sign_b, is_div, is_rem;
    logic [63:0] a_ext, b_ext, mag_a, mag_b;
    logic        div_zero, div_ovf;
    logic [63:0] special_res;

    // Operand decode: W-variants take the low word, extended according to signedness.
    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        signed_a = ~(op[0] & (op[1] | op[2]));
        signed_b = (op == MULDIV_OP_MUL) | (op == MULDIV_OP_MULH) |
                   (op == MULDIV_OP_DIV) | (op == MULDIV_OP_REM);
        a_ext    = word ? {{32{signed_a & rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
        b_ext    = word ? {{32{signed_b & rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
        sign_a   = signed_a & a_ext[63];
        sign_b   = signed_b & b_ext[63];
        mag_a    = sign_a ? -a_ext : a_ext;
        mag_b    = sign_b ? -b_ext : b_ext;
        div_zero = (b_ext == 64'd0);
        div_ovf  = signed_b & (&b_ext) &
                   (a_ext == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        if (div_zero) begin
            special_res = is_rem ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            special_res = is_rem ? 64'd0 : a_ext;
        end
        if (word) begin
            special_res = sext_word(special_res);
        end
    end

    logic [63:0]  step_rem, step_quo;
    logic [64:0]  mul_sum;
    logic [127:0] mul_next, mul_prod;
    logic [63:0]  div_raw, div_fin, calc_res, finish_res;

    ex_div_step #(.W(64)) u_div_step (
        .rem_in  (acc_q[127:64]),
        .quo_in  (acc_q[63:0]),
        .divisor (opnd_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // One iteration of either datapath, plus the result that the final iteration produces.
    always_comb begin
        mul_sum    = {1'b0, acc_q[127:64]} + {1'b0, (acc_q[0] ? opnd_q : 64'd0)};
        mul_next   = {mul_sum, acc_q[63:1]};
        mul_prod   = word_q ? {32'd0, mul_next[127:32]} : mul_next;
        div_raw    = (op_q[2] & op_q[1]) ? step_rem : step_quo;
        div_fin    = neg_q ? -div_raw : div_raw;
        calc_res   = op_q[2] ? div_fin : mul_select(op_q, neg_q, mul_prod);
        finish_res = word_q ? sext_word(calc_res) : calc_res;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [127:0] fast_prod;
    logic [63:0]  fast_res;

    always_comb begin
        fast_prod = {64'd0, mag_a} * {64'd0, mag_b};
        fast_res  = mul_select(op, sign_a ^ sign_b, fast_prod);
        if (word) begin
            fast_res = sext_word(fast_res);
        end
    end
`endif

    // Next-state logic; flush beats everything, including a start in the same cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (flush) begin
            state_d = MULDIV_IDLE;
        end else begin
            case (state_q)
                MULDIV_IDLE: begin
                    if (start) begin
                        op_d   = op;
                        word_d = word;
                        neg_d  = is_rem ? sign_a : (sign_a ^ sign_b);
                        opnd_d = mag_b;
                        cnt_d  = word ? MULDIV_CNT_WORD : MULDIV_CNT_FULL;
                        if (is_div) begin
                            acc_d = {64'd0, (word ? {mag_a[31:0], 32'd0} : mag_a)};
                        end else begin
                            acc_d = {64'd0, mag_b};
                            opnd_d = mag_a;
                        end
                        if (is_div & (div_zero | div_ovf)) begin
                            result_d = special_res;
                            state_d  = MULDIV_DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!is_div) begin
                            result_d = fast_res;
                            state_d  = MULDIV_DONE;
`endif
                        end else begin
                            state_d = MULDIV_CALC;
                        end
                    end
                end
                MULDIV_CALC: begin
                    acc_d = op_q[2] ? {step_rem, step_quo} : mul_next;
                    if (cnt_q == '0) begin
                        result_d = finish_res;
                        state_d  = MULDIV_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = MULDIV_IDLE;
            endcase
        end
        busy_d = (state_d != MULDIV_IDLE);
        done_d = (state_d == MULDIV_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MULDIV_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall_req = ((state_q == MULDIV_IDLE) & start & ~flush) | (state_q == MULDIV_CALC);
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule
